// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the iteration count.
package mdu_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  localparam int ITER = 32;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and for
// the sign correction of product, quotient and remainder.
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Magnitudes are iterated for 32 cycles, then sign-corrected in FIX.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            Start,
  input  logic [1:0]      Md_op,
  input  logic [XLEN-1:0] Read_data_1,
  input  logic [XLEN-1:0] Read_data_2,
  input  logic            Mthi,
  input  logic            Mtlo,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo,
  output logic            Busy,
  output logic            Done,
  output logic            Stall,
  output logic [1:0]      dbg_state
);

  // Handshake: Start is a one-cycle request taken only while Busy is low;
  // Busy stays high through CALC/FIX, Done pulses for one cycle when Hi/Lo
  // first hold the result, and Stall freezes the core from the Start cycle on.

  mdu_state_e            state;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            op_q;
  logic                  neg_res_q;
  logic                  neg_rem_q;
  logic [XLEN-1:0]       rs_q;
  logic [XLEN-1:0]       opnd_q;
  logic [2*XLEN-1:0]     acc;

  logic                  a_neg, b_neg, start_div;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic [XLEN:0]         mul_sum;
  logic [XLEN:0]         div_sh;
  logic                  div_ge;
  logic [XLEN-1:0]       div_diff;
  logic [2*XLEN-1:0]     acc_next;
  logic [2*XLEN-1:0]     prod_fix;
  logic [XLEN-1:0]       quo_fix, rem_fix;

  assign start_div = op_is_div(Md_op);
  assign a_neg     = op_is_signed(Md_op) & Read_data_1[XLEN-1];
  assign b_neg     = op_is_signed(Md_op) & Read_data_2[XLEN-1];

  mdu_signfix #(.W(XLEN)) u_abs_a (.value(Read_data_1), .negate(a_neg), .result(a_mag));
  mdu_signfix #(.W(XLEN)) u_abs_b (.value(Read_data_2), .negate(b_neg), .result(b_mag));

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    // The difference is below the divisor whenever it is kept, so 32 bits suffice.
    div_diff = div_sh[XLEN-1:0] - opnd_q;
    if (op_is_div(op_q)) begin
      acc_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                        : {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  mdu_signfix #(.W(2*XLEN)) u_fix_prod (.value(acc), .negate(neg_res_q), .result(prod_fix));
  mdu_signfix #(.W(XLEN)) u_fix_quo (.value(acc[XLEN-1:0]), .negate(neg_res_q), .result(quo_fix));
  mdu_signfix #(.W(XLEN)) u_fix_rem (.value(acc[2*XLEN-1:XLEN]), .negate(neg_rem_q),
                                     .result(rem_fix));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      Hi    <= '0;
      Lo    <= '0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Mthi) Hi <= Read_data_1;
          if (Mtlo) Lo <= Read_data_1;
          if (Start) begin
            state     <= CALC;
            cnt       <= '0;
            op_q      <= Md_op;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            rs_q      <= Read_data_1;
            opnd_q    <= start_div ? b_mag : a_mag;
            acc       <= {{XLEN{1'b0}}, (start_div ? a_mag : b_mag)};
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          Done  <= 1'b1;
          if (op_is_div(op_q)) begin
            // Divide by zero reports the raw dividend, not the iteration residue.
            if (opnd_q == '0) begin
              Hi <= rs_q;
              Lo <= '1;
            end else begin
              Hi <= rem_fix;
              Lo <= quo_fix;
            end
          end else begin
            {Hi, Lo} <= prod_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy      = (state != IDLE);
  assign Stall     = ~reset & (Busy | (Start & ~Busy));
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: randomized ops against an arithmetic reference
// model, with a scoreboard queue drained by a Done-driven monitor.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  Md_op;
  logic [31:0] Read_data_1, Read_data_2;
  logic        Mthi, Mtlo;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, Stall;
  logic [1:0]  dbg_state;

  mult_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .Start(Start), .Md_op(Md_op),
    .Read_data_1(Read_data_1), .Read_data_2(Read_data_2),
    .Mthi(Mthi), .Mtlo(Mtlo), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .Done(Done), .Stall(Stall), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard state
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, q, m;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      MD_MULT:  return sa * sb;
      MD_MULTU: return {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        m = sa % sb;
        return {m[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // monitor: pops an expectation on every Done pulse
  always @(negedge clock) begin
    if (!reset && Done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check("result", {Hi, Lo}, exp_q.pop_front());
        check("latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  // driver: called at a negedge (cycle 0), returns at the negedge of cycle 34
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mh, input logic ml);
    logic [63:0] r;
    r = ref_model(op, a, b);
    Start = 1'b1; Md_op = op; Read_data_1 = a; Read_data_2 = b; Mthi = mh; Mtlo = ml;
    exp_q.push_back(r);
    exp_cyc_q.push_back(cyc + 34);
    #1 check("stall_c0", 64'(Stall), 64'd1);
    @(posedge clock);
    #1;
    Start = 1'b0; Mthi = 1'b0; Mtlo = 1'b0;
    Read_data_1 = $urandom; Read_data_2 = $urandom; Md_op = 2'($urandom);
    if (mh) model_hi = a;
    if (ml) model_lo = a;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clock);
      check("stall_busy", 64'(Stall), 64'd1);
      check("busy", 64'(Busy), 64'd1);
      check("hilo_hold", {Hi, Lo}, {model_hi, model_lo});
      // Writes and a second Start while busy must be ignored.
      if (k == 5) begin Mthi = 1'b1; Mtlo = 1'b1; end
      if (k == 6) begin Mthi = 1'b0; Mtlo = 1'b0; end
      if (k == 7) Start = 1'b1;
      if (k == 8) Start = 1'b0;
    end
    @(negedge clock);
    check("stall_c34", 64'(Stall), 64'd0);
    {model_hi, model_lo} = r;
  endtask

  // idle cycle with an optional MTHI/MTLO; starts and ends at a negedge
  task automatic idle_mt();
    logic mh, ml;
    logic [31:0] v;
    mh = 1'($urandom); ml = 1'($urandom); v = $urandom;
    Mthi = mh; Mtlo = ml; Read_data_1 = v;
    @(posedge clock);
    #1 Mthi = 1'b0; Mtlo = 1'b0;
    if (mh) model_hi = v;
    if (ml) model_lo = v;
    @(negedge clock);
    check("mt_write", {Hi, Lo}, {model_hi, model_lo});
    check("stall_idle", 64'(Stall), 64'd0);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Md_op = MD_MULT; Read_data_1 = '0; Read_data_2 = '0;
    Mthi = 1'b0; Mtlo = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_hilo", {Hi, Lo}, 64'd0);
    check("reset_flags", {61'd0, Busy, Done, Stall}, 64'd0);
    reset = 1'b0;

    // directed cases
    run_op(MD_MULT,  32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0);
    run_op(MD_DIVU,  32'h7, 32'h0, 1'b0, 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    run_op(MD_DIV,   32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0);
    idle_mt();

    // randomized ops, mixing back-to-back launches with idle MTHI/MTLO gaps
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < $urandom_range(1, 3); j++) idle_mt();
      end
    end

    // reset in flight
    Start = 1'b1; Md_op = MD_MULT; Read_data_1 = $urandom; Read_data_2 = $urandom;
    @(posedge clock);
    #1 Start = 1'b0;
    repeat (4) @(negedge clock);
    Start = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1; Start = 1'b1;
    #1 check("stall_in_reset", 64'(Stall), 64'd0);
    @(posedge clock);
    #1;
    check("post_reset_hilo", {Hi, Lo}, 64'd0);
    check("post_reset_busy_done", {62'd0, Busy, Done}, 64'd0);
    @(negedge clock);
    reset = 1'b0; Start = 1'b0;
    model_hi = '0; model_lo = '0;
    Mthi = 1'b1; Read_data_1 = 32'h1234_ABCD;
    #1 check("mthi_stall", 64'(Stall), 64'd0);
    @(posedge clock);
    #1 Mthi = 1'b0;
    @(negedge clock);
    check("mthi_hi", 64'(Hi), 64'h1234_ABCD);
    check("mthi_stall_after", 64'(Stall), 64'd0);

    // bounded drain of the scoreboard
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clock);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
